cactus_spawner: RTL

- Producer side of the obstacle interface that the collision detector consumes.
- Generates the lead cactus X position, the pseudo-random gap to the second cactus, and both cactus heights.
- Scrolls the cacti left once per frame tick and recycles them when they leave the screen.
- Owns the IDLE/RUN/OVER game state: it freezes the scene when `collision_detect` asserts.

---
 rtl/dino_pkg.sv | 29 ++
 rtl/lfsr16.sv | 30 +++
 rtl/cactus_spawner.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dino_pkg.sv
// Shared types and constants for the dino obstacle pipeline: game state,
// coordinate width, LFSR taps and the cactus height table.
package dino_pkg;

  typedef logic [8:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam coord_t H0 = 9'd16;
  localparam coord_t H1 = 9'd24;
  localparam coord_t H2 = 9'd32;
  localparam coord_t H3 = 9'd40;

  function automatic coord_t height_lut(input logic [1:0] idx);
    case (idx)
      2'd0:    height_lut = H0;
      2'd1:    height_lut = H1;
      2'd2:    height_lut = H2;
      default: height_lut = H3;
    endcase
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; loads the seed while reset is low.
module lfsr16
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/cactus_spawner.sv
// Obstacle producer: scrolls two cacti left on each frame tick, respawns the
// lead one with a random gap/height, and owns the IDLE/RUN/OVER game state.
module cactus_spawner
  import dino_pkg::*;
#(
  parameter int          SCREEN_W      = 320,
  parameter int          MIN_DIST      = 96,
  parameter int          STEP_INIT     = 2,
  parameter int          STEP_MAX      = 6,
  parameter int          SPEEDUP_EVERY = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic       collision_detect,
  output logic [8:0] cactusX1,
  output logic [8:0] cactusRandDist,
  output logic [8:0] cactusHeight1,
  output logic [8:0] cactusHeight2,
  output logic       running,
  output logic       game_over,
  output logic       pass_pulse
);

  state_t     state_q, state_d;
  coord_t     x_q, x_d;
  coord_t     dist_q, dist_d;
  coord_t     h1_q, h1_d;
  coord_t     h2_q, h2_d;
  coord_t     step_q, step_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pp_q, pp_d;

  logic [15:0] lfsr_q;
  logic        lfsr_unused;
  logic [9:0]  new_x_wide;
  logic [9:0]  rand_dist;
  logic [9:0]  gap_min;
  logic [7:0]  cnt_inc;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:8];

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (collision_detect) state_d = OVER;
      OVER:    if (start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    running   = 1'b0;
    game_over = 1'b0;
    case (state_q)
      RUN:     running   = 1'b1;
      OVER:    game_over = 1'b1;
      default: ;
    endcase
  end

  // Respawn arithmetic stays 10 bits wide so the clamp never wraps.
  assign new_x_wide = {1'b0, x_q} + {1'b0, dist_q} - {1'b0, step_q};
  assign rand_dist  = 10'(MIN_DIST) + {4'd0, lfsr_q[5:0]};
  assign gap_min    = (new_x_wide < 10'(SCREEN_W)) ? (10'(SCREEN_W) - new_x_wide) : 10'd0;
  assign cnt_inc    = cnt_q + 8'd1;

  always_comb begin
    x_d    = x_q;
    dist_d = dist_q;
    h1_d   = h1_q;
    h2_d   = h2_q;
    step_d = step_q;
    cnt_d  = cnt_q;
    pp_d   = 1'b0;

    if ((state_q == IDLE) || ((state_q == OVER) && start)) begin
      x_d    = coord_t'(SCREEN_W);
      dist_d = coord_t'(MIN_DIST);
      h1_d   = H0;
      h2_d   = H0;
      step_d = coord_t'(STEP_INIT);
      cnt_d  = 8'd0;
    end else if ((state_q == RUN) && !collision_detect && tick) begin
      if (x_q >= step_q) begin
        x_d = x_q - step_q;
      end else begin
        x_d    = coord_t'(new_x_wide);
        h1_d   = h2_q;
        h2_d   = height_lut(lfsr_q[7:6]);
        dist_d = coord_t'((rand_dist > gap_min) ? rand_dist : gap_min);
        pp_d   = 1'b1;
        if (cnt_inc == 8'(SPEEDUP_EVERY)) begin
          cnt_d  = 8'd0;
          step_d = (step_q >= coord_t'(STEP_MAX)) ? coord_t'(STEP_MAX) : step_q + 9'd1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q    <= coord_t'(SCREEN_W);
      dist_q <= coord_t'(MIN_DIST);
      h1_q   <= H0;
      h2_q   <= H0;
      step_q <= coord_t'(STEP_INIT);
      cnt_q  <= 8'd0;
      pp_q   <= 1'b0;
    end else begin
      x_q    <= x_d;
      dist_q <= dist_d;
      h1_q   <= h1_d;
      h2_q   <= h2_d;
      step_q <= step_d;
      cnt_q  <= cnt_d;
      pp_q   <= pp_d;
    end
  end

  assign cactusX1       = x_q;
  assign cactusRandDist = dist_q;
  assign cactusHeight1  = h1_q;
  assign cactusHeight2  = h2_q;
  assign pass_pulse     = pp_q;

endmodule
